matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
//  Host-side transmitter for the matrix coprocessor load interface. Buffers two
//  NxN operand matrices (A then B, row-major) written by the host over a
//  valid/ready port. On start, streams them to the coprocessor as a contiguous
//  burst: carga high, one element per cycle on entrada_dado.
// PARAMETERS
//  DATA_W   8   element width; matches the coprocessor entrada_dado width
//  MAX_DIM  5   largest supported matrix dimension; buffer = 2*MAX_DIM^2 entries
// PORTS
//  clk           in   1        system clock, rising edge
//  rst_n         in   1        asynchronous reset, active low
//  tamanho       in   5        matrix dimension N, valid range 1..MAX_DIM
//  wr_valid      in   1        host element valid
//  wr_data       in   DATA_W   host element, A[0..N^2-1] then B[0..N^2-1]
//  wr_ready      out  1        loader accepts wr_data this cycle
//  start         in   1        begin streaming the buffered matrices
//  busy          out  1        high while in the STREAM state
//  done          out  1        one-cycle pulse after the last element is sent
//  err           out  1        sticky: tamanho out of range at the first write
//  carga         out  1        to coprocessor: load strobe
//  entrada_dado  out  DATA_W   to coprocessor: element being loaded
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State is FILL. count=0. Every output is 0 (wr_ready, busy, done, err, carga, entrada_dado).
//   - Takes effect immediately, including mid-stream: carga drops without waiting for clk.
//  Total elements: TOT = 2*N*N (8 for N=2, 50 for N=5). count is 6 bits wide.
//  FILL:
//   - wr_ready=1 while count<TOT and err=0.
//   - Transfer on wr_valid&wr_ready. The element is stored at buf[count], then count++.
//   - N is latched from tamanho on the first accepted write (count=0). tamanho is ignored after that until the buffer is cleared.
//   - If tamanho is 0 or >MAX_DIM when a write is offered at count=0: nothing is stored and err is set. err is sticky until reset; wr_ready stays 0 after that.
//   - When count reaches TOT, go to FULL.
//  FULL:
//   - wr_ready=0.
//   - start=1 -> STREAM on the next edge, with idx=0.
//  start in FILL (buffer not full) is ignored. No state change, no error.
//  STREAM:
//   - busy=1, wr_ready=0.
//   - carga and entrada_dado are registered. The cycle after start is sampled, carga=1 and entrada_dado=buf[0].
//   - Each following cycle sends buf[idx++].
//   - carga stays high for exactly TOT consecutive cycles, with no gaps.
//  After the last element:
//   - Next cycle: carga=0, entrada_dado=0, done=1 for one cycle, busy=0.
//   - State returns to FILL. count=0 and N is unlatched.
//   - The buffer contents are kept, but they are overwritten by the next fill.
//  start held high or re-asserted during STREAM or on the done cycle is ignored. One start gives one burst.
//  Latency: start sampled at edge t -> first carga at t+1 -> done at t+1+TOT.
//  No arithmetic on data. Elements pass through unmodified, DATA_W bits.
// TESTING
//  1. N=2, write 1..8 back to back, pulse start.
//     -> carga high 8 cycles; entrada_dado=1,2,..,8; done one cycle after; busy low again.
//  2. N=2, write 5 elements, pulse start.
//     -> no carga, state stays FILL.
//     Then write 3 more and start -> normal 8-cycle burst.
//  3. tamanho=0, then tamanho=6, offer a write.
//     -> err=1, wr_ready=0, nothing stored; only rst_n clears err.
//  4. N=5, 50 writes with random wr_valid gaps.
//     -> exactly 50 accepted; wr_ready=0 after the 50th; 50-cycle unbroken carga burst in order.
//  5. Assert rst_n=0 at the 3rd burst cycle, asynchronously to clk.
//     -> carga and entrada_dado go to 0 at once, done never pulses; the next fill starts at count=0.
//  6. Hold start high through the whole burst.
//     -> exactly one burst and one done pulse; the next fill is accepted normally.

Source files
------------

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if: host write port, control/status and coprocessor load bus.
interface matrix_stream_loader_if #(
    parameter int DATA_W = 8
);
    logic [4:0]        tamanho;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              carga;
    logic [DATA_W-1:0] entrada_dado;

    modport master (
        output tamanho, wr_valid, wr_data, start,
        input  wr_ready, busy, done, err, carga, entrada_dado
    );

    modport slave (
        input  tamanho, wr_valid, wr_data, start,
        output wr_ready, busy, done, err, carga, entrada_dado
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: buffers operand matrices A then B from the host and
// streams them to the coprocessor as one contiguous carga burst.
module matrix_stream_loader #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_stream_loader_if.slave bus
);
    localparam int         DEPTH = 2 * MAX_DIM * MAX_DIM;
    localparam logic [4:0] MAX_N = 5'(MAX_DIM);

    typedef enum logic [1:0] {FILL, FULL, STREAM} state_t;

    state_t            r_state;
    logic [5:0]        r_count;
    logic [5:0]        r_tot;
    logic [5:0]        r_idx;
    logic              r_wr_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_carga;
    logic [DATA_W-1:0] r_dado;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic       w_acc;
    logic       w_bad;
    logic       w_store;
    logic [5:0] w_tot;
    logic [5:0] w_tot_now;

    // Dimension is only checked on the first write; later writes reuse the latched total.
    assign w_acc     = (r_state == FILL) && bus.wr_valid && r_wr_ready;
    assign w_bad     = (r_count == 6'd0) && ((bus.tamanho == 5'd0) || (bus.tamanho > MAX_N));
    assign w_store   = w_acc && !w_bad;
    assign w_tot     = {5'(bus.tamanho * bus.tamanho), 1'b0};
    assign w_tot_now = (r_count == 6'd0) ? w_tot : r_tot;

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_count] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_count    <= 6'd0;
            r_tot      <= 6'd0;
            r_idx      <= 6'd0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_carga    <= 1'b0;
            r_dado     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_acc && w_bad) begin
                        r_err      <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end else if (w_acc) begin
                        r_count <= r_count + 6'd1;
                        r_tot   <= w_tot_now;
                        if (r_count + 6'd1 == w_tot_now) begin
                            r_state    <= FULL;
                            r_wr_ready <= 1'b0;
                        end
                    end else begin
                        r_wr_ready <= !r_err;
                    end
                end
                FULL: begin
                    // First element goes out on the same edge that samples start.
                    if (bus.start) begin
                        r_state <= STREAM;
                        r_busy  <= 1'b1;
                        r_carga <= 1'b1;
                        r_dado  <= r_mem[0];
                        r_idx   <= 6'd1;
                    end
                end
                STREAM: begin
                    if (r_idx == r_tot) begin
                        r_state    <= FILL;
                        r_busy     <= 1'b0;
                        r_carga    <= 1'b0;
                        r_dado     <= '0;
                        r_done     <= 1'b1;
                        r_count    <= 6'd0;
                        r_tot      <= 6'd0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_dado <= r_mem[r_idx];
                        r_idx  <= r_idx + 6'd1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign bus.wr_ready     = r_wr_ready;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.carga        = r_carga;
    assign bus.entrada_dado = r_dado;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: scoreboard bench; written elements are queued and
// popped against each carga cycle of the burst.
module tb_matrix_stream_loader;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    matrix_stream_loader_if #(.DATA_W(8)) bus();

    matrix_stream_loader #(.DATA_W(8), .MAX_DIM(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic put(input logic [7:0] d, input bit keep);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        if (keep) exp_q.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.wr_valid = 1'b0;
        end
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        bus.tamanho = 5'(n);
        for (int i = 0; i < 2 * n * n; i++) put(8'(base + i), 1'b1);
        idle(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_burst(input int tot, input bit hold);
        logic [7:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        for (int i = 0; i < tot; i++) begin
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (bus.carga !== 1'b1 || bus.busy !== 1'b1 || bus.entrada_dado !== e) begin
                n_fail++;
                $display("FAIL burst[%0d]: carga=%b busy=%b data=%0d, required carga=1 busy=1 data=%0d",
                         i, bus.carga, bus.busy, bus.entrada_dado, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bus.carga, bus.busy, bus.done, bus.entrada_dado} !== {3'b001, 8'd0}) begin
            n_fail++;
            $display("FAIL done_cycle: carga=%b busy=%b done=%b data=%0d, required 0 0 1 0",
                     bus.carga, bus.busy, bus.done, bus.entrada_dado);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.carga !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b carga=%b, required 0 0", bus.done, bus.carga);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d queued elements not streamed, required 0", exp_q.size());
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.wr_ready, bus.busy, bus.done, bus.err, bus.carga, bus.entrada_dado} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b carga=%b data=%0d, required all 0",
                     bus.wr_ready, bus.busy, bus.done, bus.err, bus.carga, bus.entrada_dado);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: wr_ready=%b busy=%b, required 1 0", bus.wr_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        fill(2, 8'd1);
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_full_ready: wr_ready=%b, required 0", bus.wr_ready);
        end
        run_burst(8, 1'b0);
    endtask

    task automatic test_partial_start();
        bus.tamanho = 5'd2;
        for (int i = 0; i < 5; i++) put(8'(11 + i), 1'b1);
        idle(1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.carga !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL partial_start[%0d]: carga=%b busy=%b wr_ready=%b, required 0 0 1",
                         i, bus.carga, bus.busy, bus.wr_ready);
            end
            @(negedge clk);
        end
        for (int i = 5; i < 8; i++) put(8'(11 + i), 1'b1);
        idle(1);
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_full_ready: wr_ready=%b, required 0", bus.wr_ready);
        end
        run_burst(8, 1'b0);
    endtask

    task automatic test_err();
        do_reset();
        bus.tamanho = 5'd0;
        put(8'hAA, 1'b0);
        idle(1);
        n_checks++;
        if (bus.err !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_zero: err=%b wr_ready=%b, required 1 0", bus.err, bus.wr_ready);
        end
        bus.tamanho = 5'd6;
        put(8'hBB, 1'b0);
        idle(2);
        bus.tamanho = 5'd2;
        put(8'hCC, 1'b0);
        idle(2);
        n_checks++;
        if (bus.err !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b wr_ready=%b, required 1 0", bus.err, bus.wr_ready);
        end
        do_reset();
        bus.tamanho = 5'd6;
        put(8'hDD, 1'b0);
        idle(1);
        n_checks++;
        if (bus.err !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_six: err=%b wr_ready=%b, required 1 0", bus.err, bus.wr_ready);
        end
        do_reset();
        n_checks++;
        if (bus.err !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cleared: err=%b wr_ready=%b, required 0 1", bus.err, bus.wr_ready);
        end
        fill(2, 8'h40);
        run_burst(8, 1'b0);
    endtask

    task automatic test_gaps();
        bus.tamanho = 5'd5;
        for (int i = 0; i < 50; i++) begin
            idle($urandom_range(0, 2));
            put(8'(i * 5 + 3), 1'b1);
        end
        idle(1);
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_full_ready: wr_ready=%b, required 0", bus.wr_ready);
        end
        put(8'hEE, 1'b0);
        idle(1);
        n_checks++;
        if (bus.wr_ready !== 1'b0 || bus.carga !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_extra: wr_ready=%b carga=%b, required 0 0", bus.wr_ready, bus.carga);
        end
        run_burst(50, 1'b0);
    endtask

    task automatic test_async_reset();
        fill(2, 8'h60);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.carga !== 1'b1 || bus.entrada_dado !== 8'h60) begin
            n_fail++;
            $display("FAIL ares_first: carga=%b data=%0d, required 1 96", bus.carga, bus.entrada_dado);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.carga !== 1'b0 || bus.entrada_dado !== 8'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ares_immediate: carga=%b data=%0d busy=%b, required 0 0 0",
                     bus.carga, bus.entrada_dado, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.carga !== 1'b0) begin
                n_fail++;
                $display("FAIL ares_hold[%0d]: done=%b carga=%b, required 0 0", i, bus.done, bus.carga);
            end
        end
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        fill(1, 8'h70);
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ares_refill_ready: wr_ready=%b, required 0", bus.wr_ready);
        end
        run_burst(2, 1'b0);
    endtask

    task automatic test_hold_start();
        fill(2, 8'h80);
        run_burst(8, 1'b1);
        fill(2, 8'h90);
        run_burst(8, 1'b0);
    endtask

    initial begin
        bus.tamanho  = 5'd0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'd0;
        bus.start    = 1'b0;
        test_reset();
        test_basic();
        test_partial_start();
        test_err();
        test_gaps();
        test_async_reset();
        test_hold_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
